// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for an N:1 valid/ready mux. It drives a registered mux select
// and captures the winning word into a one-entry output register.
module rr_mux_arbiter #(
    parameter int N = 8,
    parameter int M = 3,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [M-1:0]   out_src,
    input  logic           out_ready,
    output logic [M-1:0]   sel,
    output logic           busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [M:0]   N_EXT  = (M+1)'(N);
    localparam logic [M-1:0] LAST_I = M'(N-1);

    state_t         state_q, state_d;
    logic [M-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   data_q, data_d;
    logic [M-1:0]   src_q, src_d;
    logic [M-1:0]   sel_q, sel_d;

    logic [W-1:0]   data_arr [N];
    logic [M-1:0]   win;
    logic [M:0]     idx;
    logic           found;
    logic           any_req;
    logic           load;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign data_arr[gi] = req_data[gi*W +: W];
        end
    endgenerate

    // Scan from ptr upward, wrapping at N (not 2**M), first valid index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (M+1)'(k);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!found && req_valid[idx[M-1:0]]) begin
                found = 1'b1;
                win   = idx[M-1:0];
            end
        end
    end

    assign any_req = en && (req_valid != '0);
    assign load    = any_req && ((state_q == EMPTY) || out_ready);

    always_comb begin
        req_ready = '0;
        if (load && rst_n) begin
            req_ready = {{(N-1){1'b0}}, 1'b1} << win;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        sel_d   = sel_q;
        if (load) begin
            state_d = FULL;
            data_d  = data_arr[win];
            src_d   = win;
            sel_d   = win;
            ptr_d   = (win == LAST_I) ? '0 : win + M'(1);
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign busy      = out_valid;
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign sel       = sel_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for an N:1, W-bit mux datapath.
- Shares one output channel among N valid/ready requesters.
- Picks a winner each grant cycle, drives the registered mux select, and captures the selected word into a one-entry output register.
- Sits in front of the N-to-1 mux tree and steers it.

Parameters:
- N, 8, number of requesters (any value >= 2; need not be a power of two)
- M, 3, select width; must satisfy 2**M >= N
- W, 8, data width per requester

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  grant enable; 0 blocks new grants, output still drains
- req_valid  input  N  per-requester valid
- req_data  input  N*W  packed request data; requester i occupies bits [i*W+W-1 : i*W]
- req_ready  output  N  one-hot accept strobe, combinational
- out_valid  output  1  output register holds a word
- out_data  output  W  captured word
- out_src  output  M  index of the requester that supplied out_data
- out_ready  input  1  downstream accepts out_data
- sel  output  M  registered mux select, equal to the last granted index
- busy  output  1  equals out_valid

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_src=0, sel=0, pointer ptr=0, state=EMPTY.
  - req_ready is 0 while in reset.
- States:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - busy mirrors FULL.
- any_req = en && (req_valid != 0).
- Winner selection:
  - Scan indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Winner is the first index with req_valid set.
  - Indices >= N never exist; the scan wraps at N, not at 2**M.
- load = any_req && (state==EMPTY || out_ready).
- req_ready:
  - When load=1: one-hot at the winner, same cycle, combinational.
  - Otherwise all zero.
  - Never more than one bit set.
- On a clock edge with load=1:
  - out_data <= req_data slice of the winner; out_src <= winner; sel <= winner.
  - out_valid <= 1; state <= FULL.
  - ptr <= winner+1, wrapping N-1 -> 0.
- FULL, out_ready=1, load=0: out_valid <= 0, state <= EMPTY. out_data, out_src and sel hold their values.
- FULL, out_ready=0: hold everything; no grant; req_ready=0.
- Timing and throughput:
  - Latency from request acceptance to out_valid is 1 cycle.
  - Sustained throughput is 1 word/cycle when out_ready=1 and requests are present (simultaneous drain and load).
- en=0:
  - No load, req_ready=0, ptr frozen.
  - A FULL word still drains on out_ready.
- A requester that keeps valid high after being served is next served only after every other valid requester has been served once.
- Fairness: with all N requesting continuously and out_ready=1, each index is granted exactly once per N consecutive grants.
- req_valid may drop without having been accepted; the arbiter never depends on it staying high.
- Reset mid-transfer: a pending word is discarded; no req_ready is issued in the reset cycle; the first grant after release starts the scan at index 0.
- Outputs out_valid, out_data, out_src, sel and busy are registered; only req_ready is combinational.

Test Plan:
- Reset, then req_valid=8'h01, data0=8'hA5, out_ready=1 -> req_ready=8'h01 in cycle 0; next cycle out_valid=1, out_data=A5, out_src=0, sel=0; ptr=1.
- All 8 requesters valid continuously, data_i=8'h10+i, out_ready=1 -> out_src sequence 0,1,...,7,0; one word per cycle; req_ready one-hot each cycle.
- Backpressure: out_ready=0 with out_valid=1 and req_valid=8'hFF for 5 cycles -> req_ready=0, out_data stable. Raise out_ready -> next index granted in the same cycle.
- N=5, M=3, requesters 4 and 0 valid, ptr=4 -> grant 4, then 0; ptr wraps 4 -> 0, never reaches 5..7.
- en=0 while FULL, out_ready=1 -> word drains, out_valid=0 next cycle, req_ready stays 0. Re-enable -> grant resumes from the frozen ptr.
- Assert rst_n=0 asynchronously mid-stream (out_valid=1) -> out_valid=0 immediately without a clock edge. After release with req_valid=8'h0C -> grant 2 first.
